// File: rtl/frame_drain_stats.sv
// Drains one FRAME_LEN-word frame from the packing buffer and reports sum/min/max until acknowledged.
// Optional FRAME_XOR_EN adds xor_out, the bitwise XOR of all frame words.
module frame_drain_stats #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 32,
    parameter int SUM_W     = 21
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_enable,
    input  logic              result_ack,
    output logic [SUM_W-1:0]  sum_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic [8:0]        word_count,
    output logic              frame_done
`ifdef FRAME_XOR_EN
    ,
    output logic [DATA_W-1:0] xor_out
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [8:0] issued_reg;
    logic       cap_pend_reg;
    logic       fire;

    assign fire = word_enable && word_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            issued_reg   <= '0;
            cap_pend_reg <= 1'b0;
            word_enable  <= 1'b0;
            frame_done   <= 1'b0;
            sum_out      <= '0;
            min_out      <= '1;
            max_out      <= '0;
            word_count   <= '0;
`ifdef FRAME_XOR_EN
            xor_out      <= '0;
`endif
        end else begin
            // Read data arrives one cycle after the fire that requested it.
            cap_pend_reg <= fire;

            case (state_reg)
                IDLE: begin
                    if (word_valid) begin
                        state_reg   <= DRAIN;
                        word_enable <= 1'b1;
                        issued_reg  <= '0;
                        sum_out     <= '0;
                        min_out     <= '1;
                        max_out     <= '0;
                        word_count  <= '0;
`ifdef FRAME_XOR_EN
                        xor_out     <= '0;
`endif
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        issued_reg <= issued_reg + 9'd1;
                        if (issued_reg == 9'(FRAME_LEN - 1)) begin
                            state_reg   <= LAST;
                            word_enable <= 1'b0;
                        end
                    end
                end
                LAST: begin
                    // Wait until the final word has been folded in before reporting.
                    if (!cap_pend_reg) begin
                        state_reg  <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state_reg  <= IDLE;
                        frame_done <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (cap_pend_reg) begin
                sum_out    <= sum_out + SUM_W'(word_in);
                word_count <= word_count + 9'd1;
                if (word_in < min_out) min_out <= word_in;
                if (word_in > max_out) max_out <= word_in;
`ifdef FRAME_XOR_EN
                xor_out    <= xor_out ^ word_in;
`endif
            end
        end
    end

endmodule

// File: tb/tb_frame_drain_stats.sv
// Directed bench for frame_drain_stats: models the buffer's 1-cycle read latency and checks results.
// Build with FRAME_XOR_EN defined to also exercise xor_out.
module tb_frame_drain_stats;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_enable;
    logic        result_ack = 1'b0;
    logic [20:0] sum_out;
    logic [15:0] min_out;
    logic [15:0] max_out;
    logic [8:0]  word_count;
    logic        frame_done;
`ifdef FRAME_XOR_EN
    logic [15:0] xor_out;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_drain_stats dut (
        .clk        (clk),
        .rstn       (rstn),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_enable(word_enable),
        .result_ack (result_ack),
        .sum_out    (sum_out),
        .min_out    (min_out),
        .max_out    (max_out),
        .word_count (word_count),
        .frame_done (frame_done)
`ifdef FRAME_XOR_EN
        ,
        .xor_out    (xor_out)
`endif
    );

    function automatic logic [15:0] word_of(input int mode, input int idx);
        case (mode)
            0:       return 16'(idx);
            1:       return 16'hFFFF;
            default: return 16'(idx + 1);
        endcase
    endfunction

    task automatic apply_reset();
        rstn = 1'b0;
        word_valid = 1'b0;
        result_ack = 1'b0;
        word_in = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Drives one frame as the buffer would; returns cycles from DRAIN entry to frame_done.
    task automatic run_frame(input int mode, input int stall_at, input int stall_len,
                             output int done_cyc, output int fires, output int held_bad);
        int idx = 0;
        int cyc = 0;
        int stall_rem = 0;
        logic f;
        fires = 0;
        held_bad = 0;
        done_cyc = -1;
        word_valid = 1'b1;
        @(posedge clk); #1;
        while (cyc < 400 && !frame_done) begin
            f = word_enable && word_valid;
            @(posedge clk); #1;
            cyc++;
            if (f) begin
                word_in = word_of(mode, idx);
                idx++;
                fires++;
            end
            if (stall_rem > 0) begin
                if (!word_enable) held_bad++;
                stall_rem--;
                if (stall_rem == 0) word_valid = 1'b1;
            end else if (f && fires == stall_at) begin
                word_valid = 1'b0;
                stall_rem = stall_len;
            end
        end
        if (frame_done) done_cyc = cyc;
        else begin
            checks++; failures++;
            $display("FAIL frame_timeout: frame_done=%0b after %0d cycles, required 1", frame_done, cyc);
        end
    endtask

    task automatic check_results(input string tag, input logic [20:0] e_sum, input logic [15:0] e_min,
                                 input logic [15:0] e_max, input logic [8:0] e_cnt);
        checks++;
        if (sum_out !== e_sum) begin failures++; $display("FAIL %s_sum: got %0d required %0d", tag, sum_out, e_sum); end
        checks++;
        if (min_out !== e_min) begin failures++; $display("FAIL %s_min: got %h required %h", tag, min_out, e_min); end
        checks++;
        if (max_out !== e_max) begin failures++; $display("FAIL %s_max: got %h required %h", tag, max_out, e_max); end
        checks++;
        if (word_count !== e_cnt) begin failures++; $display("FAIL %s_count: got %0d required %0d", tag, word_count, e_cnt); end
    endtask

    task automatic test_reset();
        apply_reset();
        $display("test_reset: checking reset values");
        check_results("reset", 21'd0, 16'hFFFF, 16'h0000, 9'd0);
        checks++;
        if (word_enable !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: word_enable=%b frame_done=%b required 0 0", word_enable, frame_done);
        end
    endtask

    task automatic test_ramp();
        int dc, fr, hb;
        apply_reset();
        run_frame(0, -1, 0, dc, fr, hb);
        $display("test_ramp: done_cyc=%0d fires=%0d sum=%0d", dc, fr, sum_out);
        check_results("ramp", 21'd496, 16'd0, 16'd31, 9'd32);
        checks++;
        if (dc !== 34) begin failures++; $display("FAIL ramp_latency: got %0d required 34", dc); end
        checks++;
        if (fr !== 32) begin failures++; $display("FAIL ramp_fires: got %0d required 32", fr); end
    endtask

    task automatic test_all_ones_ack_early();
        int dc, fr, hb;
        apply_reset();
        result_ack = 1'b1;  // held through the frame: ignored until DONE
        run_frame(1, -1, 0, dc, fr, hb);
        $display("test_all_ones: done_cyc=%0d sum=%h", dc, sum_out);
        check_results("ones", 21'h1FFFE0, 16'hFFFF, 16'hFFFF, 9'd32);
        checks++;
        if (dc !== 34) begin failures++; $display("FAIL ones_latency: got %0d required 34", dc); end
        word_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0 || sum_out !== 21'h1FFFE0) begin
            failures++;
            $display("FAIL ones_ack: frame_done=%b sum=%h required 0 1fffe0", frame_done, sum_out);
        end
        result_ack = 1'b0;
    endtask

    task automatic test_stall();
        int dc, fr, hb;
        apply_reset();
        run_frame(2, 10, 5, dc, fr, hb);
        $display("test_stall: done_cyc=%0d fires=%0d sum=%0d held_bad=%0d", dc, fr, sum_out, hb);
        check_results("stall", 21'd528, 16'd1, 16'd32, 9'd32);
        checks++;
        if (fr !== 32) begin failures++; $display("FAIL stall_fires: got %0d required 32", fr); end
        checks++;
        if (hb !== 0) begin failures++; $display("FAIL stall_enable_held: dropped %0d cycles required 0", hb); end
        checks++;
        if (dc !== 39) begin failures++; $display("FAIL stall_latency: got %0d required 39", dc); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        word_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            word_in = word_of(2, i);
        end
        $display("test_mid_reset: count=%0d sum=%0d before reset", word_count, sum_out);
        check_results("pre_rst", 21'd55, 16'd1, 16'd10, 9'd10);
        #2 rstn = 1'b0;
        #1;
        check_results("mid_rst", 21'd0, 16'hFFFF, 16'h0000, 9'd0);
        checks++;
        if (word_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_enable: got %b required 0", word_enable); end
        word_valid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_hold_done();
        int dc, fr, hb, bad;
        apply_reset();
        run_frame(0, -1, 0, dc, fr, hb);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (word_enable !== 1'b0 || frame_done !== 1'b1 || sum_out !== 21'd496 ||
                min_out !== 16'd0 || max_out !== 16'd31 || word_count !== 9'd32) bad++;
        end
        $display("test_hold_done: unstable_cycles=%0d", bad);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL hold_stable: got %0d bad cycles required 0", bad); end
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL hold_ack: frame_done=%b required 0", frame_done); end
        check_results("after_ack", 21'd496, 16'd0, 16'd31, 9'd32);
        @(posedge clk); #1;
        checks++;
        if (word_enable !== 1'b1 || sum_out !== 21'd0) begin
            failures++;
            $display("FAIL next_frame: word_enable=%b sum=%0d required 1 0", word_enable, sum_out);
        end
    endtask

`ifdef FRAME_XOR_EN
    task automatic test_xor();
        int dc, fr, hb;
        apply_reset();
        run_frame(2, -1, 0, dc, fr, hb);
        $display("test_xor: xor_out=%h", xor_out);
        checks++;
        if (xor_out !== 16'h0020) begin failures++; $display("FAIL xor: got %h required 0020", xor_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_all_ones_ack_early();
        test_stall();
        test_mid_reset();
        test_hold_done();
`ifdef FRAME_XOR_EN
        test_xor();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
